// File: rtl/lsu_mem_master_if.sv
// Bundles for lsu_mem_master: core request/response handshake and memory-side access port.
// The master modport is the driving side of each bundle.
interface lsu_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_access;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_store, req_access, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_store, req_access, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_load;
  logic              mem_store;
  logic [2:0]        mem_access;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_load, mem_store, mem_access, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport slave (
    input  mem_load, mem_store, mem_access, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one memory cycle per aligned access, one-cycle response pulse.
// Build option LSU_SPLIT_EN: misaligned accesses become byte sequences instead of being rejected.
module lsu_mem_master #(
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  core,
  lsu_mem_if.master mem
);
`ifdef LSU_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGNED = 2'd1, SPLIT = 2'd2, RESP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGNED = 2'd1, RESP = 2'd3} state_e;
`endif

  function automatic logic is_illegal(input logic store, input logic [2:0] acc);
    return (acc == 3'b011) || (acc == 3'b110) || (acc == 3'b111) || (store && acc[2]);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] acc, input logic [1:0] a);
    return ((acc[1:0] == 2'b01) && (a == 2'b11)) || ((acc == 3'b010) && (a != 2'b00));
  endfunction

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic              mem_load_q, mem_load_d;
  logic              mem_store_q, mem_store_d;
  logic [2:0]        mem_access_q, mem_access_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              reject_s;

`ifdef LSU_SPLIT_EN
  // Split loads are assembled byte by byte; H/HU extension happens once the last byte lands.
  function automatic logic [31:0] split_result(input logic [2:0] acc, input logic [31:0] a);
    case (acc)
      3'b001:  return {{16{a[15]}}, a[15:0]};
      3'b101:  return {16'h0000, a[15:0]};
      default: return a;
    endcase
  endfunction

  logic [2:0]        access_q, access_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        last_k_s;
  logic [1:0]        k_nxt_s;
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    mem_load_d   = 1'b0;
    mem_store_d  = 1'b0;
    mem_access_d = 3'b000;
    mem_addr_d   = '0;
    mem_wdata_d  = 32'h0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
`ifdef LSU_SPLIT_EN
    access_d = access_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    asm_d    = asm_q;
    last_k_s = (access_q == 3'b010) ? 2'd3 : 2'd1;
    k_nxt_s  = k_q + 2'd1;
    reject_s = is_illegal(core.req_store, core.req_access);
`else
    reject_s = is_illegal(core.req_store, core.req_access) ||
               is_misaligned(core.req_access, core.req_addr[1:0]);
`endif
    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          store_d = core.req_store;
`ifdef LSU_SPLIT_EN
          access_d = core.req_access;
          addr_d   = core.req_addr;
          wdata_d  = core.req_wdata;
`endif
          if (reject_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
`ifdef LSU_SPLIT_EN
          else if (is_misaligned(core.req_access, core.req_addr[1:0])) begin
            state_d      = SPLIT;
            k_d          = 2'd0;
            asm_d        = 32'h0;
            mem_load_d   = ~core.req_store;
            mem_store_d  = core.req_store;
            mem_access_d = core.req_store ? 3'b000 : 3'b100;
            mem_addr_d   = core.req_addr;
            mem_wdata_d  = core.req_wdata;
          end
`endif
          else begin
            state_d      = ALIGNED;
            mem_load_d   = ~core.req_store;
            mem_store_d  = core.req_store;
            mem_access_d = core.req_access;
            mem_addr_d   = core.req_addr;
            mem_wdata_d  = core.req_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ALIGNED: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = store_q ? 32'h0 : mem.mem_rdata;
      end
`ifdef LSU_SPLIT_EN
      SPLIT: begin
        asm_d[{k_q, 3'b000} +: 8] = mem.mem_rdata[7:0];
        if (k_q == last_k_s) begin
          state_d      = RESP;
          k_d          = 2'd0;
          resp_valid_d = 1'b1;
          resp_rdata_d = store_q ? 32'h0 : split_result(access_q, asm_d);
        end else begin
          k_d          = k_nxt_s;
          mem_load_d   = ~store_q;
          mem_store_d  = store_q;
          mem_access_d = store_q ? 3'b000 : 3'b100;
          mem_addr_d   = addr_q + ADDR_W'(k_nxt_s);
          mem_wdata_d  = wdata_q >> {k_nxt_s, 3'b000};
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      mem_load_q   <= 1'b0;
      mem_store_q  <= 1'b0;
      mem_access_q <= 3'b000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
`ifdef LSU_SPLIT_EN
      access_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      k_q      <= 2'd0;
      asm_q    <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      mem_load_q   <= mem_load_d;
      mem_store_q  <= mem_store_d;
      mem_access_q <= mem_access_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef LSU_SPLIT_EN
      access_q <= access_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      k_q      <= k_d;
      asm_q    <= asm_d;
`endif
    end
  end

  assign core.req_ready  = (state_q == IDLE);
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem.mem_load    = mem_load_q;
  assign mem.mem_store   = mem_store_q;
  assign mem.mem_access  = mem_access_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wdata   = mem_wdata_q;
endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the request and memory address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have core request ports:
- req_valid, in, 1: request present.
- req_ready, out, 1: request may be accepted.
- req_store, in, 1: 1 = store, 0 = load.
- req_access, in, 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, 32: store data, right-justified.
REQ-005 SHALL have core response ports:
- resp_valid, out, 1: one-cycle response pulse.
- resp_rdata, out, 32: extended load data.
- resp_err, out, 1: request rejected.
REQ-006 SHALL have memory-side ports:
- mem_load, out, 1.
- mem_store, out, 1.
- mem_access, out, 3.
- mem_addr, out, ADDR_W.
- mem_wdata, out, 32: right-justified.
- mem_rdata, in, 32: combinational load result, already extended by the memory.

Function
REQ-007 SHALL use FSM states IDLE, ALIGNED, SPLIT and RESP; req_ready = (state == IDLE).
REQ-008 SHALL accept a request in cycle T when req_valid && req_ready.
- On acceptance, capture store, access, addr and wdata; later changes to the req_* inputs have no effect.
REQ-009 SHALL classify a request as misaligned when:
- access is H or HU and addr[1:0] == 11, or
- access is W and addr[1:0] != 00.
REQ-010 SHALL classify a request as illegal when:
- access is 011, 110 or 111, or
- req_store = 1 with access BU or HU.
REQ-011 SHALL handle an aligned legal request as follows:
- IDLE -> ALIGNED.
- In T+1, drive mem_load or mem_store = 1 with the captured access, addr and wdata.
- For a load, register mem_rdata at the end of T+1.
- ALIGNED -> RESP; resp_valid = 1 in T+2.
REQ-012 SHALL handle an illegal request as follows:
- IDLE -> RESP with no memory cycle.
- resp_valid = 1 and resp_err = 1 in T+1; resp_rdata = 0.
REQ-013 SHALL handle a misaligned request according to LSU_SPLIT_EN (see REQ-023, REQ-024).
REQ-014 SHALL, in SPLIT, use a byte counter k from 0 to n-1 (n = 2 for H/HU, 4 for W), one byte per cycle in T+1+k:
- mem_addr = addr + k, wrapping modulo 2^ADDR_W.
- Load: mem_load = 1, mem_access = 100; register mem_rdata[7:0] into assembly bits [8k+7:8k].
- Store: mem_store = 1, mem_access = 000, mem_wdata = wdata >> 8k.
- Exit to RESP after k = n-1; resp_valid in T+n+1.
REQ-015 SHALL produce split-load resp_rdata as:
- H: sign-extend assembly[15:0].
- HU: zero-extend assembly[15:0].
- W: assembly[31:0].
REQ-016 SHALL drive mem_load = mem_store = 0 in IDLE and RESP, and never assert both in the same cycle.
REQ-017 SHALL hold resp_valid for exactly one cycle (RESP); resp_rdata = 0 for stores and whenever resp_valid = 0.
REQ-018 SHALL return RESP -> IDLE unconditionally, so req_ready is high the cycle after resp_valid.
- Back-to-back throughput: aligned 3 cycles/request; illegal 2 cycles/request.

Reset
REQ-019 SHALL, while rst = 0, immediately force:
- state = IDLE, k = 0.
- req_ready = 1 once state = IDLE; resp_valid = 0, resp_err = 0, resp_rdata = 0.
- mem_load = 0, mem_store = 0, mem_access = 0, mem_addr = 0, mem_wdata = 0.
REQ-020 SHALL abandon an in-flight request on reset with no response.
- Bytes already stored by a split store remain written.
REQ-021 SHALL accept a new request in the first cycle with rst = 1.

Configuration
REQ-022 SHALL gate misaligned handling by macro LSU_SPLIT_EN.
REQ-023 SHALL, with LSU_SPLIT_EN defined, service misaligned requests through SPLIT per REQ-014 and REQ-015, with resp_err = 0.
REQ-024 SHALL, without LSU_SPLIT_EN, treat misaligned requests as illegal per REQ-012, and remove the SPLIT state, counter and assembly register.

Verification
REQ-025 SHALL cover: LW addr 0x10, mem_rdata = 0xDEADBEEF -> mem_load in T+1 with mem_addr 0x10; resp_valid in T+2 with rdata 0xDEADBEEF, err = 0.
REQ-026 SHALL cover (LSU_SPLIT_EN): LH addr 0x23, memory bytes 0x23 = 0x80 and 0x24 = 0xFF -> two LBU cycles at 0x23 then 0x24; resp in T+3 with rdata 0xFFFFFF80.
REQ-027 SHALL cover (LSU_SPLIT_EN): SW addr 0x41, wdata 0x11223344 -> SB cycles at 0x41..0x44 with wdata 0x11223344, 0x00112233, 0x00001122, 0x00000011; resp in T+5.
REQ-028 SHALL cover: access 011, or SH with access 101 -> no mem_load/mem_store; resp_valid and resp_err = 1 in T+1; without LSU_SPLIT_EN, LW addr 0x02 gives the same result.
REQ-029 SHALL cover: rst low during the third byte of a split SW -> mem_store drops immediately, no resp_valid, bytes 0 and 1 written, req_ready = 1 after release.
REQ-030 SHALL cover (LSU_SPLIT_EN): LW addr 0xFFFFFFFE -> byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
